// File: rtl/tpu_pkg.sv
// tpu_pkg: shared widths and the accumulator quantize/saturate function.
//   ACC_W     : accumulator width (32)
//   OUT_W_DEF : default quantized output width (16)
//   quantize(): round-half-up right shift in ACC_W+1 bits, then saturation
//               to a signed out_w-bit range; reports whether it saturated.
// Optional feature macro: MAC_DRAIN_RELU_EN (negative results clamp to 0).
package tpu_pkg;

    localparam int ACC_W     = 32;
    localparam int OUT_W_DEF = 16;

    typedef struct packed {
        logic [ACC_W:0] val;
        logic           sat;
    } quant_t;

    function automatic quant_t quantize(
        input logic signed [ACC_W-1:0] acc,
        input logic        [4:0]       sh,
        input int                      out_w
    );
        logic signed [ACC_W:0] w;
        logic signed [ACC_W:0] hi;
        logic signed [ACC_W:0] lo;
        quant_t                q;
        // One extra bit of headroom so adding the rounding constant never wraps.
        w = {acc[ACC_W-1], acc};
        if (sh != 5'd0)
            w = (w + (33'sd1 <<< (sh - 5'd1))) >>> sh;
`ifdef MAC_DRAIN_RELU_EN
        // The clamp happens before saturation, so it never counts as saturating.
        if (w[ACC_W])
            w = '0;
`endif
        hi    = (33'sd1 <<< (out_w - 1)) - 33'sd1;
        lo    = -(33'sd1 <<< (out_w - 1));
        q.sat = (w > hi) || (w < lo);
        q.val = (w > hi) ? hi : (w < lo) ? lo : w;
        return q;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count and async active-low reset.
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers/count)
//   push, wdata: write request and data (ignored when full)
//   pop        : read request (ignored when empty)
//   rdata      : entry at the head (undefined contents when empty)
//   count      : occupancy, 0..DEPTH
//   full, empty: occupancy flags
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rptr];

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok)
                wptr <= wptr + AW'(1);
            if (pop_ok)
                rptr <= rptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr] <= wdata;
    end

endmodule

// File: rtl/mac_drain.sv
// mac_drain: quantizes MAC accumulator values and buffers them in an output FIFO.
//   clk, rst_n          : clock, asynchronous active-low reset
//   acc_in, shift       : signed accumulator value and right-shift amount
//   acc_valid, acc_ready: input handshake (ready whenever the FIFO is not full)
//   out_data            : signed quantized value at the FIFO head (0 when empty)
//   out_valid, out_ready: output handshake
//   count               : FIFO occupancy
//   sat_flag, sat_clr   : sticky saturation flag and its synchronous clear
// Optional feature macro: MAC_DRAIN_RELU_EN (negative results clamp to 0).
module mac_drain
    import tpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ACC_W-1:0]       acc_in,
    input  logic [4:0]             shift,
    input  logic                   acc_valid,
    output logic                   acc_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   sat_flag,
    input  logic                   sat_clr
);

    quant_t           q;
    logic [OUT_W-1:0] q_data;
    logic [OUT_W-1:0] head;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    assign q         = quantize($signed(acc_in), shift, OUT_W);
    // Saturation already bounded the value to OUT_W signed bits.
    assign q_data    = OUT_W'(q.val);
    assign acc_ready = !full;
    assign out_valid = !empty;
    assign push      = acc_valid && acc_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = empty ? '0 : head;

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (q_data),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // A saturating push in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_flag <= 1'b0;
        else if (push && q.sat)
            sat_flag <= 1'b1;
        else if (sat_clr)
            sat_flag <= 1'b0;
    end

endmodule

// File: doc/mac_drain.md
MAC_DRAIN -- requirements
Module: mac_drain

Interface
REQ-001 Parameter DEPTH, default 4, output FIFO entries (power of two, >= 2).
REQ-002 Parameter OUT_W, default 16, output data width in bits.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 acc_in  input  32  signed MAC accumulator value.
REQ-007 shift  input  5  right-shift amount, sampled together with acc_in.
REQ-008 acc_valid  input  1  acc_in/shift valid.
REQ-009 acc_ready  output  1  block can accept a value this cycle.
REQ-010 out_data  output  OUT_W  signed quantized result at FIFO head.
REQ-011 out_valid  output  1  out_data valid.
REQ-012 out_ready  input  1  consumer accepts out_data.
REQ-013 count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-014 sat_flag  output  1  sticky saturation indicator.
REQ-015 sat_clr  input  1  synchronous clear of sat_flag.

Function
REQ-016 Push occurs on a rising edge when acc_valid && acc_ready; pop occurs when out_valid && out_ready.
REQ-017 acc_ready SHALL equal (count != DEPTH); there is no same-cycle pass-through when full, even if a pop occurs.
REQ-018 Quantization: shift 0 passes acc_in unchanged; otherwise (acc_in + 2^(shift-1)) >>> shift, computed in 33 bits with no intermediate overflow.
REQ-019 The shifted value SHALL saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-020 The quantized result is written into the FIFO at the push edge; out_valid rises the cycle after the first push into an empty FIFO (latency 1 cycle).
REQ-021 Order is strict FIFO; read/write pointers wrap modulo DEPTH.
REQ-022 Simultaneous push and pop with 0 < count < DEPTH leaves count unchanged.
REQ-023 Pop when empty and push when full SHALL have no effect.
REQ-024 out_valid = (count != 0); out_data SHALL be 0 when empty.
REQ-025 sat_flag sets on any pushed value that saturated; clears on sat_clr; set wins over simultaneous clear.

Reset
REQ-026 While rst_n low: count 0, pointers 0, out_valid 0, out_data 0, acc_ready 1, sat_flag 0.
REQ-027 Reset mid-operation discards all FIFO contents immediately; no pending push survives.

Configuration
REQ-028 Macro MAC_DRAIN_RELU_EN: when defined, negative shifted values SHALL clamp to 0 before saturation, and this clamp does not set sat_flag.
REQ-029 When MAC_DRAIN_RELU_EN is undefined, results are signed and REQ-019 applies to both bounds.

Structure
REQ-030 Package tpu_pkg SHALL hold ACC_W = 32, the default OUT_W, and the quantize/saturate function.
REQ-031 Storage SHALL be one sub-module, sync_fifo (parameters WIDTH, DEPTH), instantiated once.

Verification
REQ-032 Reset: after rst_n low -> out_valid 0, acc_ready 1, count 0, sat_flag 0, out_data 0.
REQ-033 acc_in 2, shift 0, push -> next cycle out_valid 1, out_data 2; out_ready 1 -> count 0.
REQ-034 acc_in 38, shift 2 -> out_data 10; acc_in -21, shift 1 -> out_data -10 (macro undefined).
REQ-035 acc_in 40000, shift 0 -> out_data 32767, sat_flag 1; acc_in -40000 -> -32768 (macro undefined); sat_clr -> sat_flag 0.
REQ-036 out_ready 0, push 1,2,3,4 -> count 4, acc_ready 0, 5th value held; then out_ready 1 -> 1,2,3,4 in order, 5th accepted once acc_ready returns to 1.
REQ-037 acc_in -1, shift 0 -> out_data 0 with MAC_DRAIN_RELU_EN, -1 without; sat_flag stays 0 in both cases.
